// File: rtl/ddr2_v10_1_sequencer_ram_loader.sv
// ---------------------------------------------------------------------------
// ddr2_v10_1_sequencer_ram_loader
//
// Purpose:
//   Fills the 1024x32 sequencer RAM from a byte stream. Bytes are packed
//   little-endian (byte k -> bits 8k+7:8k) into words. Each word is written to
//   the next RAM address, starting at 0. The block drives the RAM's
//   Avalon-slave pins directly and owns the RAM port while busy.
//
// Optional feature (macro SEQ_RAM_LOADER_VERIFY_EN):
//   After the last write, every loaded word is read back. The XOR of the
//   readback data is compared against the XOR of the written data. A
//   difference sets error. Without the macro no read access is ever issued
//   and ram_readdata is ignored.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   start, length_words     start pulse and word count (legal 1..2**ADDR_W)
//   s_valid, s_data,        byte stream in; a byte moves when
//   s_ready                 s_valid & s_ready
//   ram_address, ram_chipselect, ram_write, ram_writedata,
//   ram_byteenable, ram_clken, ram_readdata
//                           RAM Avalon-slave pins
//   busy, done, error       status: busy while loading, one-cycle done
//                           pulse, error stays set until the next
//                           accepted start
// ---------------------------------------------------------------------------
module ddr2_v10_1_sequencer_ram_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     length_words,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
`ifdef SEQ_RAM_LOADER_VERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t              state_q;
  logic [ADDR_W:0]     len_q;
  logic [1:0]          byte_cnt_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic [DATA_W-1:0]   checksum_q;
  logic                s_ready_q;
  logic                cs_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic [ADDR_W:0]     word_cnt_d;
  logic [DATA_W-1:0]   checksum_d;
  logic                len_legal;
  logic                last_word;

`ifdef SEQ_RAM_LOADER_VERIFY_EN
  logic [ADDR_W:0]     rd_idx_q;   // next address to read
  logic                rd_pend_q;  // a read was issued last cycle
  logic [DATA_W-1:0]   rsum_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^ram_readdata;
`endif

  always_comb begin
    word_cnt_d = word_cnt_q + CNT_ONE;
    checksum_d = checksum_q ^ wdata_q;
    len_legal  = (length_words != '0) && (length_words <= MAX_LEN);
    last_word  = (word_cnt_d == len_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      checksum_q <= '0;
      s_ready_q  <= 1'b0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef SEQ_RAM_LOADER_VERIFY_EN
      rd_idx_q   <= '0;
      rd_pend_q  <= 1'b0;
      rsum_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len_legal) begin
              state_q    <= S_LOAD;
              len_q      <= length_words;
              byte_cnt_q <= '0;
              word_cnt_q <= '0;
              checksum_q <= '0;
              s_ready_q  <= 1'b1;
              busy_q     <= 1'b1;
              error_q    <= 1'b0;
            end else begin
              // Bad length: report and finish without touching the RAM.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (s_valid && s_ready_q) begin
            wdata_q[{byte_cnt_q, 3'b000} +: 8] <= s_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // The word is complete, so the write goes out next cycle.
              // The stream is held off during that write.
              state_q   <= S_WRITE;
              s_ready_q <= 1'b0;
              cs_q      <= 1'b1;
              wr_q      <= 1'b1;
              addr_q    <= word_cnt_q[ADDR_W-1:0];
            end
          end
        end
        S_WRITE: begin
          cs_q       <= 1'b0;
          wr_q       <= 1'b0;
          checksum_q <= checksum_d;
          word_cnt_q <= word_cnt_d;
          if (last_word) begin
`ifdef SEQ_RAM_LOADER_VERIFY_EN
            state_q   <= S_VERIFY;
            cs_q      <= 1'b1;
            addr_q    <= '0;
            rd_idx_q  <= CNT_ONE;
            rd_pend_q <= 1'b0;
            rsum_q    <= '0;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
`endif
          end else begin
            state_q   <= S_LOAD;
            s_ready_q <= 1'b1;
          end
        end
`ifdef SEQ_RAM_LOADER_VERIFY_EN
        S_VERIFY: begin
          // Reads are pipelined: one is issued per cycle. Each word is folded
          // into the sum one cycle after its read.
          rd_pend_q <= cs_q;
          if (rd_pend_q) rsum_q <= rsum_q ^ ram_readdata;
          if (cs_q) begin
            if (rd_idx_q < len_q) begin
              addr_q   <= rd_idx_q[ADDR_W-1:0];
              rd_idx_q <= rd_idx_q + CNT_ONE;
            end else begin
              cs_q <= 1'b0;
            end
          end else if (rd_pend_q) begin
            // The last readback word is on ram_readdata this cycle.
            if ((rsum_q ^ ram_readdata) != checksum_q) error_q <= 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign ram_address    = addr_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = wr_q;
  assign ram_writedata  = wdata_q;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_ddr2_v10_1_sequencer_ram_loader.sv
// Bench for ddr2_v10_1_sequencer_ram_loader.
// A RAM model answers the DUT's accesses. Expected writes go into a queue
// when the last byte of a word is driven. They come off the queue when the
// DUT's write appears on the RAM pins.
module tb_ddr2_v10_1_sequencer_ram_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   length_words;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic [3:0]        ram_byteenable;
  logic              ram_clken;
  logic [31:0]       ram_readdata = '0;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  ddr2_v10_1_sequencer_ram_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .length_words(length_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .busy(busy), .done(done), .error(error)
  );

  // RAM model. It can flip bit 0 of word 2 on readback.
  logic [31:0] mem [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic        corrupt_en = 1'b0;

  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) mem[ram_address] <= ram_writedata;
      else ram_readdata <= mem[ram_address] ^
                           ((corrupt_en && ram_address == 10'd2) ? 32'h1 : 32'h0);
    end
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   writes_seen, reads_seen, dones_seen, total_reads = 0;
  int   last_wr_addr;
  bit   cs_ever;
  logic err_at_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and watch the RAM pins.
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    if (ram_chipselect) cs_ever = 1'b1;
    if (ram_chipselect && ram_write) begin
      writes_seen++;
      last_wr_addr = int'(ram_address);
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_address), 64'(e.addr));
        check("wr_data", 64'(ram_writedata), 64'(e.data));
      end
      check("s_ready_in_write", 64'(s_ready), 0);
    end
    if (ram_chipselect && !ram_write) begin
      reads_seen++;
      total_reads++;
    end
    if (done) begin
      dones_seen++;
      err_at_done = error;
    end
  endtask

  task automatic start_op(input int len);
    length_words = len[ADDR_W:0];
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // mode 0: bytes 1,2,3...; mode 1: random bytes.
  task automatic run_load(input int len, input int mode, input bit gaps,
                          input bit mid_start, input int abort_after);
    int          sent   = 0;
    int          cycles = 0;
    bit          fin    = 0;
    logic [31:0] word   = '0;
    logic [7:0]  nb;
    writes_seen = 0; reads_seen = 0; dones_seen = 0;
    exp_q.delete();
    s_valid = 1'b0;
    start_op(len);
    check("busy_after_start", 64'(busy), 1);
    check("error_cleared", 64'(error), 0);
    nb = (mode == 0) ? 8'(sent + 1) : 8'($urandom_range(255));
    while (!fin && cycles < 20000) begin
      if (sent < 4 * len && (!gaps || $urandom_range(3) != 0)) begin
        s_valid = 1'b1;
        s_data  = nb;
        if (s_ready) begin
          word[8 * (sent % 4) +: 8] = nb;
          sent++;
          if (sent % 4 == 0) begin
            exp_q.push_back(wr_t'{addr: 10'(sent / 4 - 1), data: word});
            exp_mem[sent / 4 - 1] = word;
          end
          nb = (mode == 0) ? 8'(sent + 1) : 8'($urandom_range(255));
        end
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom_range(255));
      end
      if (mid_start && cycles == 40) begin
        start = 1'b1;
        length_words = 11'd5;
      end else start = 1'b0;
      cyc();
      cycles++;
      if (abort_after > 0 && writes_seen == abort_after) begin
        reset = 1'b1;
        #1;
        check("abort_s_ready", 64'(s_ready), 0);
        check("abort_cs", 64'(ram_chipselect), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_addr", 64'(ram_address), 0);
        check("abort_wdata", 64'(ram_writedata), 0);
        fin = 1;
      end
      if (dones_seen > 0) fin = 1;
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (!fin) check("timeout", 0, 1);
  endtask

  task automatic post_checks(input int len, input logic exp_err);
    check("err_at_done", 64'(err_at_done), 64'(exp_err));
    repeat (3) cyc();
    check("done_once", 64'(dones_seen), 1);
    check("done_low", 64'(done), 0);
    check("busy_low", 64'(busy), 0);
    check("write_count", 64'(writes_seen), 64'(len));
    check("queue_empty", 64'(exp_q.size()), 0);
    check("error_sticky", 64'(error), 64'(exp_err));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    // 1. Reset, then idle.
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; length_words = '0;
    cs_ever = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (10) cyc();
    check("rst_s_ready", 64'(s_ready), 0);
    check("rst_cs", 64'(ram_chipselect), 0);
    check("rst_write", 64'(ram_write), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_addr", 64'(ram_address), 0);
    check("rst_wdata", 64'(ram_writedata), 0);
    check("byteenable", 64'(ram_byteenable), 64'hF);
    check("clken", 64'(ram_clken), 1);
    check("idle_no_cs", 64'(cs_ever), 0);

    // 3. Illegal lengths.
    for (int i = 0; i < 2; i++) begin
      cs_ever = 1'b0;
      start_op(i == 0 ? 0 : 1025);
      check("illegal_done", 64'(done), 1);
      check("illegal_error", 64'(error), 1);
      check("illegal_busy", 64'(busy), 0);
      cyc();
      check("illegal_done_off", 64'(done), 0);
      check("illegal_error_sticky", 64'(error), 1);
      check("illegal_no_cs", 64'(cs_ever), 0);
    end

    // 2. Two words, incrementing bytes, s_valid held.
    run_load(2, 0, 1'b0, 1'b0, 0);
    post_checks(2, 1'b0);

    // 4. Full depth, random bytes with gaps, start pulsed mid-load.
    run_load(1024, 1, 1'b1, 1'b1, 0);
    check("last_addr", 64'(last_wr_addr), 1023);
    post_checks(1024, 1'b0);
    mism = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== exp_mem[a]) mism++;
    check("ram_image", 64'(mism), 0);

    // 5. Asynchronous reset during a ten-word load, then a fresh load.
    run_load(10, 1, 1'b0, 1'b0, 3);
    exp_q.delete();
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    run_load(2, 1, 1'b0, 1'b0, 0);
    post_checks(2, 1'b0);

    // 6. Readback checking.
`ifdef SEQ_RAM_LOADER_VERIFY_EN
    corrupt_en = 1'b1;
    run_load(4, 1, 1'b0, 1'b0, 0);
    check("verify_reads", 64'(reads_seen), 4);
    post_checks(4, 1'b1);
    corrupt_en = 1'b0;
    run_load(4, 1, 1'b0, 1'b0, 0);
    check("verify_reads_clean", 64'(reads_seen), 4);
    post_checks(4, 1'b0);
`else
    check("no_reads", 64'(total_reads), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
